// File: rtl/qc_ldpc_pkg.sv
// Shared QC LDPC constants, serializer state type and beat-count helper.
package qc_ldpc_pkg;

    localparam int CW_W   = 162;
    localparam int INFO_W = 27;

    typedef enum logic {
        IDLE,
        SEND
    } ser_state_t;

    function automatic int nbeats(input int cw_w, input int out_w);
        return cw_w / out_w;
    endfunction

endpackage

// File: rtl/qc_cw_serializer_if.sv
// Encoder-side capture and sink-side beat stream signals of the serializer.
interface qc_cw_serializer_if #(
    parameter int CW_W  = qc_ldpc_pkg::CW_W,
    parameter int OUT_W = 9
);

    logic             in_valid;
    logic [CW_W-1:0]  in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sop;
    logic             out_eop;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sop, out_eop
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sop, out_eop
    );

endinterface

// File: rtl/qc_cw_fifo.sv
// Circular codeword buffer; head entry is visible on rd_data without a pop.
module qc_cw_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 162,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNTW = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [W-1:0]    wr_data,
    input  logic            rd_en,
    output logic [W-1:0]    rd_data,
    output logic            full,
    output logic            empty,
    output logic [CNTW-1:0] count
);

    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic            do_wr;
    logic            do_rd;

    assign full    = (count_q == CNTW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count_q <= count_q + 1'b1;
            end else if (!do_wr && do_rd) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/qc_cw_serializer.sv
// Buffers encoder codewords and streams them MSB-first as OUT_W-bit beats.
module qc_cw_serializer #(
    parameter int CW_W  = qc_ldpc_pkg::CW_W,
    parameter int OUT_W = 9,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    qc_cw_serializer_if.slave     bus,
    output logic                  ovf_err,
    output logic [CNT_W-1:0]      cw_count
);

    import qc_ldpc_pkg::*;

    localparam int NBEATS = nbeats(CW_W, OUT_W);
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int CNTW   = $clog2(DEPTH + 1);

    if (CW_W % OUT_W != 0) begin : g_bad_width
        $error("CW_W must be a multiple of OUT_W");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two, at least 2");
    end

    ser_state_t       state_q;
    logic [CW_W-1:0]  shreg_q;
    logic [BW-1:0]    beat_q;
    logic             valid_q;
    logic             sop_q;
    logic             eop_q;
    logic             ovf_q;
    logic [CNT_W-1:0] cnt_q;

    logic [CW_W-1:0]  head;
    logic             full;
    logic             empty;
    logic [CNTW-1:0]  count;
    logic             wr_en;
    logic             rd_en;
    logic             hs;

    assign bus.in_ready  = (count != CNTW'(DEPTH));
    assign wr_en         = bus.in_valid && bus.in_ready;
    assign hs            = valid_q && bus.out_ready;
    // Pop on leaving IDLE, or on the last beat so the next word follows gaplessly.
    assign rd_en         = !empty && ((state_q == IDLE) || (hs && eop_q));

    assign bus.out_valid = valid_q;
    assign bus.out_data  = shreg_q[CW_W-1 -: OUT_W];
    assign bus.out_sop   = sop_q;
    assign bus.out_eop   = eop_q;
    assign ovf_err       = ovf_q;
    assign cw_count      = cnt_q;

    qc_cw_fifo #(
        .DEPTH (DEPTH),
        .W     (CW_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (bus.in_data),
        .rd_en   (rd_en),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            if (bus.in_valid && full) begin
                ovf_q <= 1'b1;
            end
            if (hs && eop_q) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (rd_en) begin
                state_q <= SEND;
                shreg_q <= head;
                beat_q  <= '0;
                valid_q <= 1'b1;
                sop_q   <= 1'b1;
                eop_q   <= (NBEATS == 1);
            end else if (hs && eop_q) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                sop_q   <= 1'b0;
                eop_q   <= 1'b0;
            end else if (hs) begin
                shreg_q <= shreg_q << OUT_W;
                beat_q  <= beat_q + 1'b1;
                sop_q   <= 1'b0;
                eop_q   <= (beat_q == BW'(NBEATS - 2));
            end
        end
    end

endmodule

// File: tb/tb_qc_cw_serializer.sv
// Randomized bench for qc_cw_serializer against a queue-based word/beat model.
module tb_qc_cw_serializer;

    localparam int W  = 162;
    localparam int OW = 9;
    localparam int D  = 2;
    localparam int CW = 6;
    localparam int NB = W / OW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ovf;
    logic [CW-1:0] cnt;

    always #5 clk = ~clk;

    qc_cw_serializer_if #(.CW_W(W), .OUT_W(OW)) bus ();

    qc_cw_serializer #(
        .CW_W  (W),
        .OUT_W (OW),
        .DEPTH (D),
        .CNT_W (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ovf_err  (ovf),
        .cw_count (cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Model: words waiting in the buffer, plus the word on the wire.
    logic [W-1:0] mq[$];
    bit           busy;
    logic [W-1:0] mcur;
    int           mbeat;
    bit           movf;
    int           mcnt;

    logic [OW-1:0] obs[$];
    bit            osop[$];
    bit            oeop[$];
    int            hcyc[$];
    int            cyc;
    int            fv;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    function automatic logic [OW-1:0] slice(input logic [W-1:0] w, input int b);
        return w[W-1-b*OW -: OW];
    endfunction

    function automatic logic [W-1:0] rword();
        logic [191:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    task automatic model_reset();
        mq.delete();
        busy  = 0;
        mbeat = 0;
        movf  = 0;
        mcnt  = 0;
    endtask

    task automatic model_edge(input bit v, input logic [W-1:0] d, input bit r);
        int sz0;
        sz0 = mq.size();
        if (!busy) begin
            if (sz0 != 0) begin
                mcur  = mq.pop_front();
                mbeat = 0;
                busy  = 1;
            end
        end else if (r) begin
            if (mbeat == NB - 1) begin
                mcnt = (mcnt + 1) % (1 << CW);
                if (mq.size() != 0) begin
                    mcur  = mq.pop_front();
                    mbeat = 0;
                end else begin
                    busy = 0;
                end
            end else begin
                mbeat++;
            end
        end
        if (v) begin
            if (sz0 < D) mq.push_back(d);
            else movf = 1;
        end
    endtask

    task automatic compare();
        chk("out_valid", bus.out_valid, busy);
        chk("in_ready", bus.in_ready, mq.size() != D);
        chk("ovf_err", ovf, movf);
        chk("cw_count", cnt, mcnt);
        if (busy) begin
            chk("out_data", bus.out_data, slice(mcur, mbeat));
            chk("out_sop", bus.out_sop, mbeat == 0);
            chk("out_eop", bus.out_eop, mbeat == NB - 1);
            if (fv < 0) fv = cyc;
        end
    endtask

    task automatic step(input bit v, input logic [W-1:0] d, input bit r);
        @(negedge clk);
        cyc++;
        compare();
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        if (bus.out_valid && r) begin
            obs.push_back(bus.out_data);
            osop.push_back(bus.out_sop);
            oeop.push_back(bus.out_eop);
            hcyc.push_back(cyc);
        end
        @(posedge clk);
        model_edge(v, d, r);
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, '0, r);
    endtask

    task automatic clear_log();
        obs.delete();
        osop.delete();
        oeop.delete();
        hcyc.delete();
        fv = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        idle(2, 1'b0);
        #2 rst = 1'b1;
        clear_log();
    endtask

    logic [W-1:0] alt;
    logic [W-1:0] w1, w2, w3, w4;
    int           n0;
    int           bad;
    int           k;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        cyc = 0;
        model_reset();
        clear_log();
        #12;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_count", cnt, '0);
        do_reset();

        // Single alternating-pattern word.
        alt = '0;
        for (int i = 0; i < W; i++) alt[i] = (i % 2 == 1);
        idle(2, 1'b1);
        n0 = cyc + 1;
        step(1'b1, alt, 1'b1);
        idle(25, 1'b1);
        chk("lat_first_valid", fv - n0, 2);
        chk("single_beats", obs.size(), NB);
        chk("single_b0", obs[0], 9'h155);
        chk("single_b1", obs[1], 9'h0AA);
        chk("single_b17", obs[NB-1], 9'h0AA);
        chk("single_sop0", osop[0], 1'b1);
        chk("single_sop1", osop[1], 1'b0);
        chk("single_eop17", oeop[NB-1], 1'b1);
        chk("single_eop16", oeop[NB-2], 1'b0);
        chk("single_count", cnt, 1);

        // Two words three cycles apart.
        do_reset();
        w1 = rword();
        w2 = rword();
        step(1'b1, w1, 1'b1);
        idle(2, 1'b1);
        step(1'b1, w2, 1'b1);
        idle(45, 1'b1);
        chk("two_beats", obs.size(), 2 * NB);
        chk("two_no_bubble", hcyc[2*NB-1] - hcyc[0], 2 * NB - 1);
        chk("two_sop2", osop[NB], 1'b1);
        chk("two_w2b0", obs[NB], slice(w2, 0));
        chk("two_count", cnt, 2);
        chk("two_ovf", ovf, 1'b0);

        // Back-to-back burst while stalled: shifter takes one, buffer two, the fourth drops.
        do_reset();
        w1 = rword();
        w2 = rword();
        w3 = rword();
        w4 = rword();
        step(1'b1, w1, 1'b0);
        step(1'b1, w2, 1'b0);
        step(1'b1, w3, 1'b0);
        step(1'b1, w4, 1'b0);
        idle(3, 1'b0);
        chk("burst_in_ready", bus.in_ready, 1'b0);
        chk("burst_ovf", ovf, 1'b1);
        chk("burst_stall_beats", obs.size(), 0);
        idle(70, 1'b1);
        chk("burst_beats", obs.size(), 3 * NB);
        chk("burst_w1b0", obs[0], slice(w1, 0));
        chk("burst_w2b0", obs[NB], slice(w2, 0));
        chk("burst_w3b17", obs[3*NB-1], slice(w3, NB - 1));
        chk("burst_count", cnt, 3);

        // One word under random stalls.
        do_reset();
        w1 = rword();
        step(1'b1, w1, 1'b0);
        for (int i = 0; i < 200 && obs.size() < NB; i++) begin
            step(1'b0, '0, 1'($urandom_range(0, 1)));
        end
        chk("stall_beats", obs.size(), NB);
        bad = 0;
        for (int i = 0; i < NB && i < obs.size(); i++) begin
            if (obs[i] !== slice(w1, i)) bad++;
        end
        chk("stall_seq_errs", bad, 0);
        chk("stall_ovf", ovf, 1'b0);

        // Async reset in the middle of a codeword.
        do_reset();
        w1 = rword();
        step(1'b1, w1, 1'b1);
        for (int i = 0; i < 40 && obs.size() < 7; i++) idle(1, 1'b1);
        chk("rstmid_reach_b7", obs.size(), 7);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstmid_valid", bus.out_valid, 1'b0);
        chk("rstmid_count", cnt, '0);
        chk("rstmid_ovf", ovf, 1'b0);
        chk("rstmid_in_ready", bus.in_ready, 1'b1);
        model_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle(2, 1'b1);
        #2 rst = 1'b1;
        clear_log();
        w2 = rword();
        step(1'b1, w2, 1'b1);
        idle(25, 1'b1);
        chk("rstmid_new_beats", obs.size(), NB);
        chk("rstmid_new_b0", obs[0], slice(w2, 0));
        chk("rstmid_new_sop", osop[0], 1'b1);
        chk("rstmid_new_count", cnt, 1);

        // Counter wrap: 2^CW + 1 words at one per NB cycles.
        do_reset();
        k = 0;
        for (int i = 0; i < ((1 << CW) + 1) * NB; i++) begin
            if (i % NB == 0) step(1'b1, rword(), 1'b1);
            else step(1'b0, '0, 1'b1);
        end
        idle(25, 1'b1);
        chk("wrap_count", cnt, 1);
        chk("wrap_ovf", ovf, 1'b0);

        // Random traffic with random sink stalls.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 15, rword(), $urandom_range(0, 99) < 65);
        end
        idle(80, 1'b1);
        chk("rand_drained", bus.out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
